rv_ri_fetch_exec: RTL and testbench
===================================

Name: rv_ri_fetch_exec

Overview:
- Single-cycle RV64 fetch/execute slice: PC register, instruction memory, main decode, ALU-control decode, 32x64 register file and 64-bit ALU.
- Executes R-type and I-type integer ALU instructions and writes results back.
- Sits ahead of the branch and load/store datapaths, which are separate blocks; exposes PC, instruction, operands and ALU flags for them.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words; must be a power of 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_we  in  1  instruction-memory write enable.
- imem_waddr  in  log2(IMEM_DEPTH)  word index to write.
- imem_wdata  in  32  instruction word to write.
- dbg_raddr  in  5  debug register-file read address.
- dbg_rdata  out  64  register-file contents at dbg_raddr.
- pc  out  64  current PC.
- instruction  out  32  word fetched at pc.
- alu_ctrl  out  4  ALU control code (ALU_CO).
- read_data_1  out  64  rs1 value (instr[19:15]).
- read_data_2  out  64  rs2 value (instr[24:20]).
- alu_result  out  64  ALU output.
- zero  out  1  alu_result == 0.
- overflow  out  1  signed overflow of add/sub.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_PC.
  - All 32 registers = 0.
  - Instruction memory is not cleared.
  - Outputs are combinational from this state.
- Fetch:
  - instruction = imem[pc[2+log2(IMEM_DEPTH)-1:2]] (combinational read).
  - pc[1:0] are ignored; addresses wrap modulo IMEM_DEPTH words.
  - Each rising edge with reset=1: pc <= pc+4. Wraps at 2^64.
- Imem write:
  - Synchronous on the rising edge when imem_we=1; allowed during reset.
  - A write to the word currently being fetched is visible after that edge.
  - Power-up contents are 0.
- Main decode (opcode = instr[6:0]):
  - 0110011 R-type: ALUop=10, ALUsrc=0, RegWrite=1.
  - 0010011 I-type ALU: ALUop=11, ALUsrc=1, RegWrite=1.
  - Any other opcode: ALUop=00, ALUsrc=0, RegWrite=0 (treated as a NOP; PC still advances).
- ALU control (funct3 = instr[14:12], funct7 = instr[31:25]):
  - ALUop 00 -> 0010 (add).
  - ALUop 01 -> 0110 (sub); encoding reserved for branch use.
  - ALUop 10 (R-type):
    - funct3 000 with funct7 0000000 -> 0010 (add).
    - funct3 000 with funct7 0100000 -> 0110 (sub).
    - funct3 111 -> 0000 (and).
    - funct3 110 -> 0001 (or).
  - ALUop 11 (I-type): funct7 ignored; funct3 000 -> add, 111 -> and, 110 -> or.
  - Unsupported funct combinations -> 0010, and RegWrite is forced to 0.
- Operands:
  - A = read_data_1.
  - B = ALUsrc ? sign-extended instr[31:20] : read_data_2.
- ALU:
  - 64-bit, wrap-around arithmetic.
  - overflow = signed overflow for add/sub; 0 for and/or.
  - zero = (alu_result == 0).
- Register file:
  - Two combinational read ports plus a combinational debug read port.
  - One synchronous write port: rd = instr[11:7], data = alu_result, on the rising edge when RegWrite=1 and reset=1.
  - x0 reads as 0 and writes to it are discarded.
  - Reads return the pre-edge value; no write-to-read bypass is needed in a single-cycle design.
- Latency: one instruction per cycle. Results of a write are visible on read ports and dbg_rdata after the write edge.

Decomposition:
- Shared package rv_ri_pkg holds:
  - Opcode constants (OP_RTYPE = 0110011, OP_ITYPE = 0010011).
  - ALUop encodings (00, 01, 10, 11).
  - ALU_CO codes (AND = 0000, OR = 0001, ADD = 0010, SUB = 0110).
- One sub-module, rv_ri_alu_ctrl: combinational ALUop/funct3/funct7 -> alu_ctrl plus a valid flag.

Test Plan:
- Reset, then release: pc=0, all registers read 0, zero=1. Any imem contents must not be lost.
- Load imem: word0 = addi x1,x0,5; word1 = addi x2,x0,-3. After 2 edges: x1=5, x2=0xFFFF_FFFF_FFFF_FFFD, pc=8.
- Load word2 = add x3,x1,x2; word3 = sub x4,x1,x1.
  - In word2's cycle: alu_ctrl=0010, alu_result=2.
  - In word3's cycle: alu_ctrl=0110, alu_result=0, zero=1, and x4=0 after the edge.
- Set x5=0x7FFF_FFFF_FFFF_FFFF, then add x6,x5,x1: overflow=1, alu_result=0x8000_0000_0000_0004.
- Write to x0: addi x0,x0,7 leaves x0 reading 0. An instruction word of 0 performs no register write and pc still advances by 4.
- Assert reset mid-program between edges: pc becomes RESET_PC immediately and registers clear. Execution restarts from word0 after release.

Source files
------------

// File: rtl/rv_ri_pkg.sv
// Shared constants and types for the RV64 R/I-type fetch/execute slice.
// Opcodes, ALUop encodings, ALU control codes and the main decode bundle.
package rv_ri_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
  } dec_t;

  function automatic logic [63:0] sext12(
    input logic [11:0] imm
  );
    return {{52{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/rv_ri_alu_ctrl.sv
// ALU control decode: ALUop plus funct3/funct7 to an ALU code.
// valid drops for funct combinations the ALU does not implement.
module rv_ri_alu_ctrl
  import rv_ri_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       valid
);

  // Map ALUop/funct fields to an ALU code; default add, flag unsupported.
  always_comb begin
    alu_ctrl = ALU_ADD;
    valid    = 1'b1;
    unique case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_R: begin
        unique case (1'b1)
          (funct3 == 3'b000 && funct7 == F7_BASE):
            alu_ctrl = ALU_ADD;
          (funct3 == 3'b000 && funct7 == F7_ALT):
            alu_ctrl = ALU_SUB;
          (funct3 == 3'b111):
            alu_ctrl = ALU_AND;
          (funct3 == 3'b110):
            alu_ctrl = ALU_OR;
          default:
            valid = 1'b0;
        endcase
      end
      ALUOP_I: begin
        unique case (funct3)
          3'b000:  alu_ctrl = ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          default: valid = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/rv_ri_fetch_exec.sv
// Single-cycle RV64 fetch/execute slice for R-type and I-type ALU ops.
// PC, instruction memory, decode, 32x64 register file and 64-bit ALU.
module rv_ri_fetch_exec
  import rv_ri_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          IMEM_DEPTH = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [4:0]                    dbg_raddr,
  output logic [63:0]                   dbg_rdata,
  output logic [63:0]                   pc,
  output logic [31:0]                   instruction,
  output logic [3:0]                    alu_ctrl,
  output logic [63:0]                   read_data_1,
  output logic [63:0]                   read_data_2,
  output logic [63:0]                   alu_result,
  output logic                          zero,
  output logic                          overflow
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [63:0] regs [32];

  dec_t        dec;
  logic        funct_ok;
  logic        reg_write;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [63:0] op_b;
  logic [63:0] sum;
  logic [63:0] diff;

  // PC register: restart at RESET_PC, otherwise advance one word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc + 64'd4;
  end

  // Instruction memory write port; kept out of reset so code survives it.
  always_ff @(posedge clock) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign instruction = imem[pc[AW+1:2]];

  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign rd  = instruction[11:7];

  // Main decode from the opcode; anything unrecognised becomes a NOP.
  always_comb begin
    dec = '{alu_op: ALUOP_ADD, alu_src: 1'b0, reg_write: 1'b0};
    unique case (1'b1)
      (instruction[6:0] == OP_RTYPE):
        dec = '{alu_op: ALUOP_R, alu_src: 1'b0, reg_write: 1'b1};
      (instruction[6:0] == OP_ITYPE):
        dec = '{alu_op: ALUOP_I, alu_src: 1'b1, reg_write: 1'b1};
      default: ;
    endcase
  end

  rv_ri_alu_ctrl u_alu_ctrl (
    .alu_op   (dec.alu_op),
    .funct3   (instruction[14:12]),
    .funct7   (instruction[31:25]),
    .alu_ctrl (alu_ctrl),
    .valid    (funct_ok)
  );

  assign reg_write = dec.reg_write & funct_ok;

  assign read_data_1 = (rs1 == 5'd0) ? 64'd0 : regs[rs1];
  assign read_data_2 = (rs2 == 5'd0) ? 64'd0 : regs[rs2];
  assign dbg_rdata   = (dbg_raddr == 5'd0) ? 64'd0 : regs[dbg_raddr];

  assign op_b = dec.alu_src ? sext12(instruction[31:20]) : read_data_2;
  assign sum  = read_data_1 + op_b;
  assign diff = read_data_1 - op_b;

  // ALU datapath with signed overflow for the arithmetic codes.
  always_comb begin
    alu_result = sum;
    overflow   = 1'b0;
    unique case (alu_ctrl)
      ALU_AND: alu_result = read_data_1 & op_b;
      ALU_OR:  alu_result = read_data_1 | op_b;
      ALU_SUB: begin
        alu_result = diff;
        overflow   = (read_data_1[63] != op_b[63]) &&
                     (diff[63] != read_data_1[63]);
      end
      default: begin
        alu_result = sum;
        overflow   = (read_data_1[63] == op_b[63]) &&
                     (sum[63] != read_data_1[63]);
      end
    endcase
  end

  assign zero = (alu_result == 64'd0);

  // Register file write port; x0 is never written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_write && rd != 5'd0) begin
      regs[rd] <= alu_result;
    end
  end

endmodule

// File: tb/tb_rv_ri_fetch_exec.sv
// Directed bench for rv_ri_fetch_exec: loads a 64-word program in reset
// and checks fetch, decode, ALU, writeback, wrap and mid-run reset.
module tb_rv_ri_fetch_exec;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [4:0]  dbg_raddr;
  logic [63:0] dbg_rdata;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic [3:0]  alu_ctrl;
  logic [63:0] read_data_1;
  logic [63:0] read_data_2;
  logic [63:0] alu_result;
  logic        zero;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog [64];

  always #5 clock = ~clock;

  rv_ri_fetch_exec #(
    .RESET_PC   (64'd0),
    .IMEM_DEPTH (64)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata),
    .pc          (pc),
    .instruction (instruction),
    .alu_ctrl    (alu_ctrl),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .alu_result  (alu_result),
    .zero        (zero),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic dbg(input string tag, input logic [4:0] a,
                     input logic [63:0] exp);
    dbg_raddr = a;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0] = 32'h00500093;
    prog[1] = 32'hFFD00113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h40108233;
    prog[4] = 32'h80000293;
    for (int i = 5; i <= 56; i++) prog[i] = 32'h005282B3;
    prog[57] = 32'hFFF28293;
    prog[58] = 32'h00128333;
    prog[59] = 32'h00700013;
    prog[60] = 32'h00000000;
    prog[61] = 32'h001091B3;
    prog[62] = 32'h0FF17393;
    prog[63] = 32'h0A00E413;

    reset      = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    dbg_raddr  = '0;

    #2;
    imem_we = 1'b1;
    step();
    chk("rst_pc", pc, 64'd0);
    chk("rst_instr0", {32'd0, instruction}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_res", alu_result, 64'd0);
    dbg("rst_x1", 5'd1, 64'd0);
    dbg("rst_x31", 5'd31, 64'd0);

    for (int i = 0; i < 64; i++) begin
      imem_waddr = 6'(i);
      imem_wdata = prog[i];
      step();
    end
    imem_we = 1'b0;
    chk("rst_pc_hold", pc, 64'd0);
    chk("imem_kept", {32'd0, instruction}, 64'h00500093);

    reset = 1'b1;
    #1;
    chk("w0_res", alu_result, 64'd5);
    chk("w0_ctrl", {60'd0, alu_ctrl}, 64'h2);
    step();
    chk("pc4", pc, 64'd4);
    dbg("x1", 5'd1, 64'd5);
    step();
    chk("pc8", pc, 64'd8);
    dbg("x2", 5'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("w2_ctrl", {60'd0, alu_ctrl}, 64'h2);
    chk("w2_res", alu_result, 64'd2);
    chk("w2_ovf", {63'd0, overflow}, 64'd0);
    step();
    chk("w3_ctrl", {60'd0, alu_ctrl}, 64'h6);
    chk("w3_res", alu_result, 64'd0);
    chk("w3_zero", {63'd0, zero}, 64'd1);
    step();
    dbg("x4", 5'd4, 64'd0);
    dbg("x3", 5'd3, 64'd2);
    chk("w4_res", alu_result, 64'hFFFF_FFFF_FFFF_F800);

    for (int i = 0; i < 53; i++) step();
    dbg("x5_min", 5'd5, 64'h8000_0000_0000_0000);
    chk("w57_ovf", {63'd0, overflow}, 64'd1);
    step();
    dbg("x5_max", 5'd5, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("w58_pc", pc, 64'd232);
    chk("w58_ctrl", {60'd0, alu_ctrl}, 64'h2);
    chk("w58_res", alu_result, 64'h8000_0000_0000_0004);
    chk("w58_ovf", {63'd0, overflow}, 64'd1);
    step();
    dbg("x6", 5'd6, 64'h8000_0000_0000_0004);
    chk("w59_res", alu_result, 64'd7);
    step();
    dbg("x0", 5'd0, 64'd0);
    chk("w60_pc", pc, 64'd240);
    step();
    chk("w61_pc", pc, 64'd244);
    dbg("x1_keep", 5'd1, 64'd5);
    chk("w61_ctrl", {60'd0, alu_ctrl}, 64'h2);
    chk("w61_res", alu_result, 64'd10);
    step();
    dbg("x3_nowr", 5'd3, 64'd2);
    chk("w62_ctrl", {60'd0, alu_ctrl}, 64'h0);
    chk("w62_res", alu_result, 64'hFD);
    chk("w62_ovf", {63'd0, overflow}, 64'd0);
    step();
    dbg("x7", 5'd7, 64'hFD);
    chk("w63_ctrl", {60'd0, alu_ctrl}, 64'h1);
    chk("w63_res", alu_result, 64'hA5);
    step();
    dbg("x8", 5'd8, 64'hA5);
    chk("wrap_pc", pc, 64'd256);
    chk("wrap_instr", {32'd0, instruction}, 64'h00500093);
    step();
    step();

    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 64'd0);
    dbg("mid_rst_x1", 5'd1, 64'd0);
    dbg("mid_rst_x5", 5'd5, 64'd0);
    step();
    chk("mid_rst_hold", pc, 64'd0);
    reset = 1'b1;
    #1;
    chk("restart_instr", {32'd0, instruction}, 64'h00500093);
    step();
    chk("restart_pc", pc, 64'd4);
    dbg("restart_x1", 5'd1, 64'd5);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
